mips_multicycle_ctrl: RTL and testbench

Main control FSM of the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It is the write-port initiator for the register file: it drives RegWrite, RegDst and MemtoReg, which the register file consumes as a responder. It also drives the PC, IR, memory and ALU-mux controls, and handshakes with memory through mem_ready.

---
 rtl/mips_multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// It sequences fetch, decode, execute, memory access and writeback.
// It also drives the register-file write port (RegWrite/RegDst/MemtoReg),
// the PC/IR/memory strobes and the ALU operand-mux controls.
// The 4-bit state register is the only storage. Every output is decoded
// combinationally from the state, and from op/mem_ready where they matter.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    assign state = cur_state;

    // State register; reset abandons any partial instruction and returns to FETCH.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // Next-state and output decode for the current state.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        nxt_state  = S_FETCH;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (cur_state)
            S_FETCH: begin
                // The PC+4 add runs every cycle. IR and PC commit only when memory delivers.
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target PC + (imm<<2) is computed speculatively here.
                ALUSrcB = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXECUTE;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD      = 1'b1;
                nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                // The write strobe is held until memory acknowledges it.
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                nxt_state  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 2'b10;
                instr_done = 1'b1;
            end
            default: nxt_state = S_FETCH;  // codes 12-15: outputs stay 0, recover to FETCH
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. Each instruction is expanded into the
// cycle-by-cycle schedule implied by its opcode and memory wait counts.
// The schedule is then played against the DUT, which is checked every cycle.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       IRWrite, PCWrite, Branch, MemWrite, IorD;
    logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int vectors;
    int miscompares;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word, in the same order as mk() below.
    logic [16:0] obs;
    assign obs = {IRWrite, PCWrite, Branch, MemWrite, IorD, RegWrite, RegDst,
                  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op};

    function automatic logic [16:0] mk(
        input logic irw, pcw, br, mw, iord, rw, rd, m2r, srca,
        input logic [1:0] srcb, aluop, pcsrc,
        input logic done, ill);
        return {irw, pcw, br, mw, iord, rw, rd, m2r, srca, srcb, aluop, pcsrc, done, ill};
    endfunction

    typedef struct {
        logic [3:0]  st;
        logic        mr;
        logic        hold_op;
        logic [16:0] outs;
    } cyc_t;

    cyc_t sched[$];

    function automatic void push(input logic [3:0] st, input logic mr,
                                 input logic hold, input logic [16:0] outs);
        cyc_t c;
        c.st = st; c.mr = mr; c.hold_op = hold; c.outs = outs;
        sched.push_back(c);
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o == OP_RTYPE || o == OP_LW || o == OP_SW ||
               o == OP_BEQ || o == OP_ADDI || o == OP_J;
    endfunction

    // Reference model: the cycle schedule of one instruction. fw = fetch
    // wait cycles, mw = memory wait cycles in the data-access phase.
    function automatic void build(input logic [5:0] o, input int fw, input int mw);
        logic rnd;
        for (int i = 0; i < fw; i++)
            push(4'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0));
        push(4'd0, 1'b1, 1'b0, mk(1,1,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0));
        rnd = 1'($urandom);
        if (!is_legal(o)) begin
            push(4'd1, rnd, 1'b1, mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 1,1));
            return;
        end
        push(4'd1, rnd, 1'b1, mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0,0));
        if (o == OP_LW || o == OP_SW) begin
            rnd = 1'($urandom);
            push(4'd2, rnd, 1'b1, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0));
        end
        if (o == OP_LW) begin
            for (int i = 0; i < mw; i++)
                push(4'd3, 1'b0, 1'b0, mk(0,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0));
            push(4'd3, 1'b1, 1'b0, mk(0,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0));
            rnd = 1'($urandom);
            push(4'd4, rnd, 1'b0, mk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1,0));
        end else if (o == OP_SW) begin
            for (int i = 0; i < mw; i++)
                push(4'd5, 1'b0, 1'b0, mk(0,0,0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0));
            push(4'd5, 1'b1, 1'b0, mk(0,0,0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0));
        end else if (o == OP_RTYPE) begin
            rnd = 1'($urandom);
            push(4'd6, rnd, 1'b0, mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0,0));
            rnd = 1'($urandom);
            push(4'd7, rnd, 1'b0, mk(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 1,0));
        end else if (o == OP_BEQ) begin
            rnd = 1'($urandom);
            push(4'd8, rnd, 1'b0, mk(0,0,1,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0));
        end else if (o == OP_ADDI) begin
            rnd = 1'($urandom);
            push(4'd9, rnd, 1'b0, mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0));
            rnd = 1'($urandom);
            push(4'd10, rnd, 1'b0, mk(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 1,0));
        end else begin
            rnd = 1'($urandom);
            push(4'd11, rnd, 1'b0, mk(0,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0));
        end
    endfunction

    // Drives and checks up to 'limit' cycles of the schedule, then clears it.
    // Outside the op-sampling states op is scrambled to show it is ignored.
    task automatic play(input logic [5:0] o, input string name, input int limit);
        int n;
        n = (limit < sched.size()) ? limit : sched.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_ready = sched[i].mr;
            op = sched[i].hold_op ? o : 6'($urandom);
            #1;
            vectors++;
            if ({state, obs} !== {sched[i].st, sched[i].outs}) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h",
                         name, i, state, obs, sched[i].st, sched[i].outs);
            end
        end
        sched.delete();
    endtask

    // Ends with the DUT in FETCH, reset released, and mem_ready low at the next edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input string name);
        build(o, fw, mw);
        play(o, name, 1000);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        op = 6'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({state, obs} !== {4'd0, mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0)}) begin
            miscompares++;
            $display("FAIL reset_hold: got state=%0d ctrl=%05h, expected state=0 ctrl=%05h",
                     state, obs, mk(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0));
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if ({IRWrite, PCWrite, state} !== {2'b11, 4'd0}) begin
            miscompares++;
            $display("FAIL reset_fetch_gating: got IRWrite=%b PCWrite=%b state=%0d, expected 1 1 0",
                     IRWrite, PCWrite, state);
        end
        @(negedge clk);
        reset = 1'b1;
        op = OP_J;
        @(negedge clk);
        #1;
        vectors++;
        if (state !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_release: got state=%0d, expected 1", state);
        end
        do_reset();
    endtask

    task automatic test_lw();
        run_instr(OP_LW, 0, 0, "lw");
    endtask

    task automatic test_rtype();
        run_instr(OP_RTYPE, 0, 0, "rtype");
    endtask

    task automatic test_sw_wait();
        run_instr(OP_SW, 0, 3, "sw_wait");
    endtask

    task automatic test_beq_j_addi();
        run_instr(OP_BEQ, 0, 0, "beq");
        run_instr(OP_J, 0, 0, "j");
        run_instr(OP_ADDI, 0, 0, "addi");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(OP_RTYPE, 1, 0, "after_illegal");
    endtask

    // Reset while waiting in MEMRD must abandon the load without a RegWrite pulse.
    task automatic test_reset_mid_memrd();
        build(OP_LW, 0, 5);
        play(OP_LW, "reset_mid_memrd_pre", 4);
        reset = 1'b0;
        #1;
        vectors++;
        if ({state, RegWrite, MemWrite} !== {4'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_mid_memrd: got state=%0d RegWrite=%b MemWrite=%b, expected 0 0 0",
                     state, RegWrite, MemWrite);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({state, RegWrite, MemWrite} !== {4'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_mid_memrd_hold: got state=%0d RegWrite=%b MemWrite=%b, expected 0 0 0",
                     state, RegWrite, MemWrite);
        end
        mem_ready = 1'b0;
        reset = 1'b1;
        run_instr(OP_ADDI, 0, 0, "after_reset_addi");
    endtask

    task automatic test_random();
        logic [5:0] list[6];
        logic [5:0] o;
        list = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(9) == 0) begin
                do o = 6'($urandom); while (is_legal(o));
            end else begin
                o = list[$urandom_range(5)];
            end
            run_instr(o, $urandom_range(3), $urandom_range(3), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] list[6];
        list = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};
        for (int n = 0; n < 6; n++)
            run_instr(list[n], 0, 0, "back_to_back");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        mem_ready = 1'b0;
        op = 6'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_sw_wait();
        test_beq_j_addi();
        test_illegal();
        test_reset_mid_memrd();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
